vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_ctrl.sv | 142 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: pixel-rate divider, h/v counters, registered syncs and blank-gated RGB.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (then test_mode selects it).
module vga_timing_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    input  logic        test_mode,
    output logic        pixel_tick,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        disp_en,
    output logic        frame_start,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  r_port,
    output logic [3:0]  g_port,
    output logic [3:0]  b_port
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic       SYNC_ON = 1'(SYNC_POL);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             wrap_q, wrap_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q;
    logic [11:0]      rgb_q, rgb_d;
    logic [11:0]      pix_rgb;

    assign pixel_tick = (div_q == DIV_LAST);
    assign x_pos      = h_q;
    assign y_pos      = v_q;
    assign disp_en    = (h_q < H_VIS) && (v_q < V_VIS);

    always_comb begin
        div_d  = div_q + DIV_W'(1);
        h_d    = h_q;
        v_d    = v_q;
        wrap_d = 1'b0;
        if (pixel_tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
                // Remember the frame wrap so frame_start lines up with the other registered outputs.
                wrap_d = (v_q == V_LAST);
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);

    logic [9:0]  bar_idx;
    logic [11:0] bar_rgb;

    always_comb begin
        bar_idx = h_q / BAR_W;
        case (bar_idx[2:0])
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    assign pix_rgb = test_mode ? bar_rgb : rgb_in;
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign pix_rgb          = rgb_in;
`endif

    always_comb begin
        hs_d  = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vs_d  = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_ON : ~SYNC_ON;
        rgb_d = disp_en ? pix_rgb : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            wrap_q <= 1'b0;
            fs_q   <= 1'b0;
            hs_q   <= ~SYNC_ON;
            vs_q   <= ~SYNC_ON;
            rgb_q  <= 12'h000;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            wrap_q <= wrap_d;
            fs_q   <= wrap_q;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
        end
    end

    assign frame_start = fs_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign r_port      = rgb_q[11:8];
    assign g_port      = rgb_q[7:4];
    assign b_port      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl using a shrunk raster so whole frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int CLK_DIV = 4;
    localparam int HV = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VV = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT * CLK_DIV;
    localparam logic POL = 1'b0;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rgb_in;
    logic        test_mode;
    logic        pixel_tick;
    logic [9:0]  x_pos, y_pos;
    logic        disp_en, frame_start, h_sync, v_sync;
    logic [3:0]  r_port, g_port, b_port;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_div = 0, m_h = 0, m_v = 0;
    logic m_wrap = 1'b0;
    int   hs_low = 0, vs_low = 0, fs_cnt = 0;
    bit   win = 1'b0;

    vga_timing_ctrl #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0)
    ) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .test_mode(test_mode),
        .pixel_tick(pixel_tick), .x_pos(x_pos), .y_pos(y_pos), .disp_en(disp_en),
        .frame_start(frame_start), .h_sync(h_sync), .v_sync(v_sync),
        .r_port(r_port), .g_port(g_port), .b_port(b_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] bar_colour(input int x);
        case ((x / (HV / 8)) % 8)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic cycle(input logic rst_v, input logic [11:0] rgb_v, input logic tm_v);
        exp_t        e;
        exp_t        o;
        logic        tick;
        logic        de;
        logic [11:0] pix;
        @(negedge clk);
        reset     = rst_v;
        rgb_in    = rgb_v;
        test_mode = tm_v;
        tick = (m_div == CLK_DIV - 1);
        de   = (m_h < HV) && (m_v < VV);
        check("pixel_tick", 32'(pixel_tick), 32'(tick));
        check("x_pos", 32'(x_pos), 32'(m_h));
        check("y_pos", 32'(y_pos), 32'(m_v));
        check("disp_en", 32'(disp_en), 32'(de));
        pix = rgb_v;
`ifdef VGA_TEST_PATTERN_EN
        if (tm_v) pix = bar_colour(m_h);
`endif
        if (rst_v) begin
            e = '{hs: ~POL, vs: ~POL, fs: 1'b0, rgb: 12'h000};
        end else begin
            e.hs  = (m_h >= HV + HFP && m_h < HV + HFP + HS) ? POL : ~POL;
            e.vs  = (m_v >= VV + VFP && m_v < VV + VFP + VS) ? POL : ~POL;
            e.fs  = m_wrap;
            e.rgb = de ? pix : 12'h000;
        end
        sbq.push_back(e);
        if (rst_v) begin
            m_div = 0; m_h = 0; m_v = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = tick && (m_h == HT - 1) && (m_v == VT - 1);
            if (tick) begin
                m_div = 0;
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end else begin
                m_div = m_div + 1;
            end
        end
        @(posedge clk);
        #1;
        o = sbq.pop_front();
        check("h_sync", 32'(h_sync), 32'(o.hs));
        check("v_sync", 32'(v_sync), 32'(o.vs));
        check("frame_start", 32'(frame_start), 32'(o.fs));
        check("rgb", 32'({r_port, g_port, b_port}), 32'(o.rgb));
        if (win) begin
            if (h_sync == POL) hs_low++;
            if (v_sync == POL) vs_low++;
            if (frame_start) fs_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; rgb_in = 12'h000; test_mode = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: outputs idle, counters at origin.
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'(i * 12'h3A5), 1'b0);

        // Free run for three frames with random colour, tallying sync and frame pulses.
        win = 1'b1;
        for (int i = 0; i < 3 * FRAME + 5; i++) cycle(1'b0, 12'($urandom), 1'b0);
        win = 1'b0;
        check("hs_low_clks", 32'(hs_low), 32'(3 * VT * HS * CLK_DIV));
        check("vs_low_clks", 32'(vs_low), 32'(3 * VS * HT * CLK_DIV));
        check("frame_pulses", 32'(fs_cnt), 32'd3);

        // Constant white: blanking alone decides what reaches the ports.
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 12'hFFF, 1'b0);

        // Reset pulse mid-frame.
        for (int i = 0; i < 2 * FRAME && !(m_h == 10 && m_v == 5); i++)
            cycle(1'b0, 12'($urandom), 1'b0);
        check("mid_x", 32'(x_pos), 32'd10);
        check("mid_y", 32'(y_pos), 32'd5);
        cycle(1'b1, 12'hABC, 1'b0);
        fs_cnt = 0;
        win = 1'b1;
        for (int i = 0; i < 2 * FRAME + 2; i++) cycle(1'b0, 12'($urandom), 1'b0);
        win = 1'b0;
        check("frame_pulses_after_rst", 32'(fs_cnt), 32'd2);

        // test_mode with green input: bars when the pattern is built in, passthrough otherwise.
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 12'h0F0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
